// File: rtl/collector_pkg.sv
// Shared constants and helpers for the serial-to-parallel collector and its FIFO.
package collector_pkg;

  // Ceiling log2 (0 for v <= 1); sizes pointers and counters.
  function automatic int unsigned clog2_f(input int unsigned v);
    int unsigned r;
    r = 0;
    while ((64'd1 << r) < 64'(v)) r++;
    return r;
  endfunction

  function automatic int unsigned beats_f(input int unsigned width, input int unsigned lanes);
    return width / lanes;
  endfunction

  // Word must split evenly into lanes; FIFO depth must be a power of two, at least 2.
  function automatic bit cfg_ok_f(input int unsigned width, input int unsigned lanes,
                                  input int unsigned depth);
    return (lanes != 0) && (width % lanes == 0) && (depth >= 2) && ((depth & (depth - 1)) == 0);
  endfunction

endpackage

// File: rtl/sync_fifo.sv
// Synchronous FIFO with registered head word (0 when empty) and simultaneous push/pop.
module sync_fifo
  import collector_pkg::*;
#(
  parameter int unsigned WIDTH = 25,
  parameter int unsigned DEPTH = 4
) (
  input  logic                             clk_i,
  input  logic                             rst_i,
  input  logic                             push_i,
  input  logic [WIDTH-1:0]                 wdata_i,
  input  logic                             pop_i,
  output logic [WIDTH-1:0]                 rdata_o,
  output logic                             valid_o,
  output logic                             full_o,
  output logic [clog2_f(DEPTH+1)-1:0]      count_o
);

  localparam int unsigned PW = clog2_f(DEPTH);
  localparam int unsigned CW = clog2_f(DEPTH + 1);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [PW-1:0]    rd_q, rd_d, wr_q, wr_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [WIDTH-1:0] head_q, head_d;
  logic             valid_q, full_q;
  logic             pop_c, push_c;

  // Pop is ignored when empty; a push into a full FIFO needs a same-cycle pop.
  assign pop_c  = pop_i & valid_q;
  assign push_c = push_i & (~full_q | pop_c);

  always_comb begin
    rd_d   = rd_q;
    wr_d   = wr_q;
    cnt_d  = cnt_q;
    head_d = head_q;
    if (pop_c)  rd_d = rd_q + PW'(1);
    if (push_c) wr_d = wr_q + PW'(1);
    if (push_c && !pop_c)      cnt_d = cnt_q + CW'(1);
    else if (pop_c && !push_c) cnt_d = cnt_q - CW'(1);
    // Head is kept in a register so data never depends combinationally on inputs.
    if (pop_c) begin
      if (cnt_q == CW'(1)) head_d = push_c ? wdata_i : '0;
      else                 head_d = mem_q[rd_q + PW'(1)];
    end else if (!valid_q && push_c) begin
      head_d = wdata_i;
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      rd_q    <= '0;
      wr_q    <= '0;
      cnt_q   <= '0;
      head_q  <= '0;
      valid_q <= 1'b0;
      full_q  <= 1'b0;
    end else begin
      rd_q    <= rd_d;
      wr_q    <= wr_d;
      cnt_q   <= cnt_d;
      head_q  <= head_d;
      valid_q <= (cnt_d != '0);
      full_q  <= (cnt_d == CW'(DEPTH));
    end
  end

  always_ff @(posedge clk_i) begin
    if (push_c) mem_q[wr_q] <= wdata_i;
  end

  assign rdata_o = head_q;
  assign valid_o = valid_q;
  assign full_o  = full_q;
  assign count_o = cnt_q;

endmodule

// File: rtl/multilane_collector.sv
// Multi-lane serial-to-parallel collector: assembles LANES bits per beat into
// OUTPUT_WIDTH-bit words and queues them in a FIFO with sticky overrun reporting.
module multilane_collector
  import collector_pkg::*;
#(
  parameter int unsigned OUTPUT_WIDTH = 25,
  parameter int unsigned LANES        = 1,
  parameter int unsigned DEPTH        = 4,
  parameter bit          LSB_FIRST    = 1'b1
) (
  input  logic                          fast_clk,
  input  logic                          reset,
  input  logic [LANES-1:0]              serial_in,
  input  logic                          bit_valid,
  input  logic                          align,
  output logic [OUTPUT_WIDTH-1:0]       data,
  output logic                          data_valid,
  input  logic                          data_take,
  output logic [clog2_f(DEPTH+1)-1:0]   word_count,
  output logic                          overrun,
  input  logic                          overrun_clr
);

  localparam int unsigned BEATS = beats_f(OUTPUT_WIDTH, LANES);
  localparam int unsigned BW    = (BEATS > 1) ? clog2_f(BEATS) : 1;

  if (!cfg_ok_f(OUTPUT_WIDTH, LANES, DEPTH)) begin : g_cfg_err
    $error("multilane_collector: OUTPUT_WIDTH must be a multiple of LANES and DEPTH a power of two >= 2");
  end

  logic [BW-1:0]           beat_q, beat_d, beat_c;
  logic [OUTPUT_WIDTH-1:0] sr_q, sr_d;
  logic                    overrun_q, overrun_d;
  logic                    done_c, push_c, ovr_set_c, fifo_full;

  // Slice write for the effective beat; align restarts the word at beat 0.
  always_comb begin
    beat_c = align ? '0 : beat_q;
    beat_d = beat_q;
    sr_d   = sr_q;
    done_c = 1'b0;
    if (bit_valid) begin
      for (int unsigned b = 0; b < BEATS; b++) begin
        if (beat_c == BW'(b)) begin
          if (LSB_FIRST) sr_d[b*LANES +: LANES] = serial_in;
          else           sr_d[OUTPUT_WIDTH-(b+1)*LANES +: LANES] = serial_in;
        end
      end
      done_c = (beat_c == BW'(BEATS - 1));
      beat_d = done_c ? '0 : beat_c + BW'(1);
    end else if (align) begin
      beat_d = '0;
    end
  end

  assign push_c    = done_c & (~fifo_full | data_take);
  assign ovr_set_c = done_c & fifo_full & ~data_take;

  always_comb begin
    overrun_d = overrun_q;
    if (overrun_clr) overrun_d = 1'b0;
    if (ovr_set_c)   overrun_d = 1'b1;
  end

  always_ff @(posedge fast_clk or posedge reset) begin
    if (reset) begin
      beat_q    <= '0;
      sr_q      <= '0;
      overrun_q <= 1'b0;
    end else begin
      beat_q    <= beat_d;
      sr_q      <= sr_d;
      overrun_q <= overrun_d;
    end
  end

  sync_fifo #(
    .WIDTH (OUTPUT_WIDTH),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk_i   (fast_clk),
    .rst_i   (reset),
    .push_i  (push_c),
    .wdata_i (sr_d),
    .pop_i   (data_take),
    .rdata_o (data),
    .valid_o (data_valid),
    .full_o  (fifo_full),
    .count_o (word_count)
  );

  assign overrun = overrun_q;

endmodule

// File: doc/multilane_collector.md
# multilane_collector

Parametrised serial-to-parallel collector for the input side of the datapath. It accepts 1..N serial lanes per clock and assembles them into OUTPUT_WIDTH-bit words, with selectable bit order. Completed words are buffered in a DEPTH-entry FIFO with a valid/take handshake and overrun reporting. It supersedes the single-lane input_collector wherever more throughput or downstream back-pressure is required.

## Interface
- OUTPUT_WIDTH, 25: assembled word width; must be an integer multiple of LANES.
- LANES, 1: serial bits captured per valid beat.
- DEPTH, 4: output FIFO entries; power of two, at least 2.
- LSB_FIRST, 1: 1 means the first beat fills the least-significant slice; 0 means the first beat fills the most-significant slice.

Ports:
- fast_clk  in  1  sole clock; all state updates on the rising edge.
- reset  in  1  asynchronous, active-high; clears all state.
- serial_in  in  LANES  serial data, one bit per lane per beat.
- bit_valid  in  1  serial_in holds a valid beat this cycle.
- align  in  1  discard the partial word; this cycle's beat, if any, becomes beat 0.
- data  out  OUTPUT_WIDTH  head-of-FIFO word; 0 when the FIFO is empty.
- data_valid  out  1  FIFO not empty.
- data_take  in  1  consumer pops the head word; ignored when data_valid=0.
- word_count  out  $clog2(DEPTH+1)  FIFO occupancy.
- overrun  out  1  sticky; a completed word was dropped because the FIFO was full.
- overrun_clr  in  1  clears overrun.

## Operation
- BEATS = OUTPUT_WIDTH/LANES. The beat counter runs 0..BEATS-1 and advances only when bit_valid=1.
- Beat b, LSB_FIRST=1: lane i is written to word bit b*LANES+i.
- Beat b, LSB_FIRST=0: lane i is written to word bit OUTPUT_WIDTH-(b+1)*LANES+i, so lane LANES-1 is the MSB of each slice.
- The shift register is not cleared between words. Every bit is overwritten before the next push.
- Beat BEATS-1 completes the word, and the counter wraps to 0.
  - If the FIFO is not full, or data_take=1 in the same cycle, the word is pushed.
  - Otherwise the word is dropped and overrun is set.
- align=1 resets the counter to 0. If bit_valid=1 in the same cycle, that beat is written as beat 0 and the counter goes to 1. align never affects the FIFO.
- FIFO order is strictly first-in first-out. When empty, data is 0.
- Push and pop in the same cycle:
  - Occupancy is unchanged.
  - When full, the push succeeds.
  - When empty, only the push takes effect, because there is no bypass.
- overrun_clr and a new overrun in the same cycle: set wins.
- Reset mid-word or with the FIFO non-empty discards everything. No partial word survives.

## Timing
- Reset values: data=0, data_valid=0, word_count=0, overrun=0. The beat counter and FIFO pointers are 0.
- Latency: the word is completed at rising edge k, and data_valid/data/word_count reflect it after edge k (registered, visible in cycle k+1).
- Pop: data_take sampled at edge k. The next word, or 0, is presented after edge k.
- Throughput: one word per BEATS cycles with continuous bit_valid. Gaps in bit_valid stall assembly without loss.
- Inputs are sampled only on rising fast_clk. There are no combinational input-to-output paths.

## Structure
- Shared package collector_pkg holds:
  - the BEATS derivation;
  - the pointer/count width function (clog2);
  - an elaboration-time check that OUTPUT_WIDTH % LANES == 0 and that DEPTH is a power of two.
- Sub-module sync_fifo (WIDTH, DEPTH): registered storage with wrapping read/write pointers, count, full/empty, simultaneous push/pop. It is reusable by output_emitter's successor.
- The top level contains the beat counter, slice write logic, overrun flag and sync_fifo instance.

## Test plan
- Default params, reset, send 3461 LSB-first over 25 beats → data_valid rises the cycle after beat 24, data=3461, word_count=1; data_take → data_valid=0, data=0.
- LANES=4, OUTPUT_WIDTH=24, LSB_FIRST=0, send 0xABCDEF as 6 nibbles starting 0xA → data=0xABCDEF after 6 beats; bit_valid gaps of 3 cycles between beats give the same result.
- DEPTH=4, push 5 words 1..5 with no take → word_count=4, overrun=1, pops return 1,2,3,4; overrun_clr → overrun=0.
- Full FIFO, word completes with data_take=1 → word_count stays 4, the new word is last in order, overrun stays 0.
- 10 beats, then align with bit_valid=1, then 24 more beats of 69 → data=69 and no word from the aborted partial.
- Assert reset mid-word and with 2 words queued → all outputs 0 asynchronously; a following full word is received correctly.
